// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state
// encoding, the hard-wired zero register index and the default multi-cycle latency.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MC_LAT_DEFAULT = 4;
  localparam int         CNT_W          = 4;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags an ID source operand that depends
// on a load still sitting in EX, only while the controller is in RUN.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       run,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 never carries a real dependency, so a load targeting it cannot stall ID.
  assign lu = run && id_valid && ex_valid && ex_is_load &&
              (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller with multi-cycle EX occupancy.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DEFAULT  // legal range 2..15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_is_mc,
  input  logic        br_mispredict,
  input  logic        exc_flush,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_bubble,
  output logic        pc_redirect,
  output logic        mc_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  // The start cycle is spent in RUN, so MC_BUSY covers the remaining MC_LAT-1 cycles.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  hazard_detect u_hazard_detect (
    .run        (state_q == RUN),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .lu         (lu)
  );

  // NOTE: asynchronous reset lives in the sensitivity list; state uses <= so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output and next-state variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_redirect  = 1'b0;
    // mc_busy reports occupancy of EX, including the cycle in which a trap aborts it.
    mc_busy      = (state_q == MC_BUSY);

    if (exc_flush) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      cnt_d        = '0;
    end else if (state_q == MC_BUSY) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
      if (cnt_q == '0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (ex_valid && br_mispredict) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ex_valid && ex_is_mc) begin
      // A coincident load-use hazard is absorbed by the MC stall: no bubble.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
      state_d     = MC_BUSY;
      cnt_d       = CNT_INIT;
    end else if (lu) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (if_id_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the stall/flush rules.
module tb_pipe_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_is_load, ex_is_mc, br_mispredict, exc_flush;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic       id_ex_bubble, pc_redirect, mc_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_ctrl #(.MC_LAT(LAT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_is_load    (ex_is_load),
    .ex_is_mc      (ex_is_mc),
    .br_mispredict (br_mispredict),
    .exc_flush     (exc_flush),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_stall   (id_ex_stall),
    .id_ex_bubble  (id_ex_bubble),
    .pc_redirect   (pc_redirect),
    .mc_busy       (mc_busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, pc_redirect, mc_busy}
  logic [6:0] dut_out;
  assign dut_out = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                    id_ex_bubble, pc_redirect, mc_busy};

  int checks   = 0;
  int failures = 0;

  // Model: number of further cycles the multi-cycle op keeps EX busy.
  int m_rem      = 0;
  int m_stalls   = 0;
  int m_flushes  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_is_mc = 0;
    br_mispredict = 0; exc_flush = 0;
  endtask

  // Expected outputs from the rules, in priority order: trap, busy, mispredict, MC start, load-use.
  task automatic model(output logic [6:0] exp, output int nxt);
    bit lu;
    lu = (m_rem == 0) && id_valid && ex_valid && ex_is_load && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    exp = '0;
    nxt = m_rem;
    exp[0] = (m_rem > 0);
    if (exc_flush) begin
      exp[4] = 1; exp[2] = 1; exp[1] = 1; nxt = 0;
    end else if (m_rem > 0) begin
      exp[6] = 1; exp[5] = 1; exp[3] = 1; nxt = m_rem - 1;
    end else if (ex_valid && br_mispredict) begin
      exp[4] = 1; exp[2] = 1; exp[1] = 1;
    end else if (ex_valid && ex_is_mc) begin
      exp[6] = 1; exp[5] = 1; exp[3] = 1; nxt = LAT - 1;
    end else if (lu) begin
      exp[6] = 1; exp[5] = 1; exp[2] = 1;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input string tag);
    logic [6:0] exp;
    int nxt;
    #1;
    model(exp, nxt);
    check(tag, 32'(dut_out), 32'(exp));
    @(posedge clk);
    m_rem = nxt;
    if (exp[6]) m_stalls++;
    if (exp[4]) m_flushes++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    rstn = 0;
    #1;
    check("reset_outputs", 32'(dut_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    m_rem = 0; m_stalls = 0; m_flushes = 0;
  endtask

  initial begin
    set_idle();
    rstn = 1;
    @(negedge clk);
    do_reset();

    // Load x5 followed by a consumer of x5: one stall cycle.
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
    #1 check("lu_stall", 32'(dut_out), 32'b1100100);
    cycle("lu_stall_model");
    set_idle();
    #1 check("lu_release", 32'(dut_out), 32'd0);
    cycle("lu_release_model");

    // rs2 path.
    ex_valid = 1; ex_is_load = 1; ex_rd = 9; id_valid = 1; id_rs2 = 9; id_use_rs2 = 1;
    #1 check("lu_rs2", 32'(dut_out), 32'b1100100);
    cycle("lu_rs2_model");

    // Load to x0 is never a hazard.
    set_idle();
    ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_valid = 1; id_rs1 = 0; id_use_rs1 = 1;
    #1 check("lu_x0", 32'(dut_out), 32'd0);
    cycle("lu_x0_model");

    // Multi-cycle op: id_ex_stall cycles 0..3, mc_busy cycles 1..3.
    set_idle();
    ex_valid = 1; ex_is_mc = 1;
    for (int c = 0; c <= LAT; c++) begin
      #1;
      check($sformatf("mc_id_ex_stall_c%0d", c), 32'(id_ex_stall), (c < LAT) ? 32'd1 : 32'd0);
      check($sformatf("mc_busy_c%0d", c), 32'(mc_busy), (c >= 1 && c < LAT) ? 32'd1 : 32'd0);
      cycle($sformatf("mc_model_c%0d", c));
      set_idle();
    end

    // Mispredict coincident with load-use: redirect/flush wins, no stall.
    ex_valid = 1; ex_is_load = 1; ex_rd = 7; id_valid = 1; id_rs1 = 7; id_use_rs1 = 1;
    br_mispredict = 1;
    #1 check("br_over_lu", 32'(dut_out), 32'b0010110);
    cycle("br_over_lu_model");
    set_idle();

    // MC start coincident with load-use: MC stall, no bubble.
    ex_valid = 1; ex_is_mc = 1; ex_is_load = 1; ex_rd = 3; id_valid = 1; id_rs1 = 3; id_use_rs1 = 1;
    #1 check("mc_over_lu", 32'(dut_out), 32'b1101000);
    cycle("mc_over_lu_model");
    set_idle();
    cycle("mc_busy1_model");

    // Trap at cycle 2 of MC: redirect/flush now, back in RUN next cycle.
    exc_flush = 1;
    #1;
    check("exc_redirect", 32'(pc_redirect), 32'd1);
    check("exc_flush_out", 32'(if_id_flush), 32'd1);
    check("exc_no_stall", 32'({pc_stall, if_id_stall, id_ex_stall}), 32'd0);
    cycle("exc_model");
    set_idle();
    #1 check("exc_after", 32'(dut_out), 32'd0);
    cycle("exc_after_model");

    // Reset pulse mid-MC aborts the op immediately.
    ex_valid = 1; ex_is_mc = 1;
    cycle("mc2_start_model");
    set_idle();
    cycle("mc2_busy_model");
    do_reset();
    cycle("post_reset_idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = $urandom_range(0, 1) == 1;
      id_use_rs2    = $urandom_range(0, 1) == 1;
      ex_valid      = ($urandom_range(0, 4) != 0);
      ex_rd         = 5'($urandom_range(0, 3));
      ex_is_load    = $urandom_range(0, 1) == 1;
      ex_is_mc      = ($urandom_range(0, 7) == 0);
      br_mispredict = !ex_is_mc && ($urandom_range(0, 9) == 0);
      exc_flush     = ($urandom_range(0, 29) == 0);
      cycle($sformatf("rand_%0d", i));
    end
    set_idle();

`ifdef PIPE_CTRL_PERF_EN
    #1;
    check("perf_stall_cnt", perf_stall_cnt, 32'(m_stalls));
    check("perf_flush_cnt", perf_flush_cnt, 32'(m_flushes));
    // Wrap: preload to all-ones, one stall cycle lands on zero.
    for (int w = 0; w < LAT + 1; w++) cycle("perf_drain");
    force dut.perf_stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.perf_stall_cnt;
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
    cycle("perf_wrap_stall");
    set_idle();
    #1 check("perf_stall_wrap", perf_stall_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MC_LAT, default 4: EX occupancy in cycles of a multi-cycle op (MUL/DIV); legal range 2..15.
REQ-002 Ports, in order (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on rising edge.
- rstn, in, 1: asynchronous active-low reset.
- id_valid, in, 1: ID holds a valid instruction.
- id_rs1, in, 5: ID source register 1.
- id_rs2, in, 5: ID source register 2.
- id_use_rs1, in, 1: ID instruction reads rs1.
- id_use_rs2, in, 1: ID instruction reads rs2.
- ex_valid, in, 1: EX holds a valid instruction.
- ex_rd, in, 5: EX destination register.
- ex_is_load, in, 1: EX instruction is a load.
- ex_is_mc, in, 1: EX instruction is multi-cycle.
- br_mispredict, in, 1: EX branch resolved mispredicted.
- exc_flush, in, 1: trap/exception flush request.
- pc_stall, out, 1: hold PC.
- if_id_stall, out, 1: hold IF/ID register.
- if_id_flush, out, 1: clear IF/ID register.
- id_ex_stall, out, 1: hold ID/EX register.
- id_ex_bubble, out, 1: load NOP into ID/EX.
- pc_redirect, out, 1: take redirect target this cycle.
- mc_busy, out, 1: multi-cycle op occupying EX.

Function
REQ-003 State register has two states, RUN and MC_BUSY, plus a 4-bit down-counter cnt; outputs are a combinational decode of state and inputs.
REQ-004 Load-use hazard (lu) = RUN & id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-005 On lu: pc_stall=1, if_id_stall=1, id_ex_bubble=1, in the same cycle, for exactly one cycle; no state change.
REQ-006 In RUN with ex_valid & ex_is_mc: next state MC_BUSY, cnt <= MC_LAT-2. This cycle asserts pc_stall, if_id_stall and id_ex_stall.
REQ-007 In MC_BUSY: pc_stall=1, if_id_stall=1, id_ex_stall=1, mc_busy=1. cnt decrements each cycle; when cnt==0, next state is RUN.
REQ-008 Consequence of REQ-006/007: the op stays in EX for exactly MC_LAT cycles, and ID/EX advances on cycle MC_LAT+1.
REQ-009 br_mispredict is qualified by ex_valid and RUN.
- Effect: pc_redirect=1, if_id_flush=1, id_ex_bubble=1 for one cycle.
- Overrides lu: no stalls are asserted that cycle.
REQ-010 exc_flush has highest priority in any state.
- Outputs: pc_redirect=1, if_id_flush=1, id_ex_bubble=1; all stalls are 0.
- Next state is RUN, cnt <= 0; an in-flight MC_BUSY is aborted.
REQ-011 br_mispredict and ex_is_mc are ignored while in MC_BUSY.
REQ-012 Simultaneous ex_is_mc and lu in RUN: the MC stall (REQ-006) applies and id_ex_bubble=0.
REQ-013 Whenever no condition in REQ-005..REQ-012 applies, all outputs are 0.

Reset
REQ-014 On rstn low, asynchronously: state=RUN, cnt=0.
- With idle inputs, all outputs read 0.
- Reset during MC_BUSY aborts the op with no residual stall.
REQ-015 The first rising edge after rstn deasserts evaluates inputs normally.

Configuration
REQ-016 Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
- perf_stall_cnt increments each cycle pc_stall=1; perf_flush_cnt increments each cycle if_id_flush=1.
- Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Structure
REQ-017 Shared package pipe_ctrl_pkg holds:
- the state encoding (RUN=1'b0, MC_BUSY=1'b1);
- REG_ZERO=5'd0;
- MC_LAT_DEFAULT=4.
REQ-018 One sub-module, hazard_detect: combinational load-use comparator producing lu (REQ-004); it is instantiated once.

Verification
REQ-019 Load x5, then add reading x5 (ex_rd=5, id_rs1=5) -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, then all 0.
REQ-020 Load with ex_rd=0, ID reads x0 -> no stall.
REQ-021 MC_LAT=4, ex_is_mc at cycle 0 -> id_ex_stall=1 for cycles 0..3, 0 at cycle 4; mc_busy=1 for cycles 1..3.
REQ-022 br_mispredict coincident with lu -> pc_redirect=if_id_flush=id_ex_bubble=1 and pc_stall=0 for one cycle.
REQ-023 exc_flush at cycle 2 of MC_BUSY -> redirect and flush that cycle; state RUN and mc_busy=0 next cycle.
REQ-024 PIPE_CTRL_PERF_EN defined, perf_stall_cnt preloaded to 0xFFFFFFFF, one stall cycle -> perf_stall_cnt=0; rstn pulse mid-MC -> all outputs 0 immediately.
